// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB sizes, field widths and page-field struct
package tlb_pkg;
  localparam int TLBNUM = 16;
  localparam int IDX_W  = $clog2(TLBNUM);
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;
endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - single-entry tag compare; V deliberately plays no part
module tlb_match
  import tlb_pkg::*;
(
  input  logic [VPN2_W-1:0] entry_vpn2,
  input  logic [ASID_W-1:0] entry_asid,
  input  logic              entry_g,
  input  logic [VPN2_W-1:0] s_vpn2,
  input  logic [ASID_W-1:0] s_asid,
  output logic              hit
);
  assign hit = (entry_vpn2 == s_vpn2) && (entry_g || (entry_asid == s_asid));
endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - 16-entry fully associative joint TLB, two lookup ports,
// one synchronous write port and one combinational read port
module tlb
  import tlb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDX_W-1:0]  s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDX_W-1:0]  s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  input  logic [IDX_W-1:0]  r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1
);
  logic [VPN2_W-1:0] vpn2_q  [TLBNUM];
  logic [ASID_W-1:0] asid_q  [TLBNUM];
  logic              g_q     [TLBNUM];
  page_t             page0_q [TLBNUM];
  page_t             page1_q [TLBNUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i]  <= '0;
        asid_q[i]  <= '0;
        g_q[i]     <= 1'b0;
        page0_q[i] <= '0;
        page1_q[i] <= '0;
      end
    end else if (we) begin
      vpn2_q[w_index]  <= w_vpn2;
      asid_q[w_index]  <= w_asid;
      g_q[w_index]     <= w_g;
      page0_q[w_index] <= '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0};
      page1_q[w_index] <= '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1};
    end
  end

  logic hit0 [TLBNUM];
  logic hit1 [TLBNUM];

  for (genvar i = 0; i < TLBNUM; i++) begin : g_match
    tlb_match u_match0 (
      .entry_vpn2(vpn2_q[i]), .entry_asid(asid_q[i]), .entry_g(g_q[i]),
      .s_vpn2(s0_vpn2), .s_asid(s0_asid), .hit(hit0[i])
    );
    tlb_match u_match1 (
      .entry_vpn2(vpn2_q[i]), .entry_asid(asid_q[i]), .entry_g(g_q[i]),
      .s_vpn2(s1_vpn2), .s_asid(s1_asid), .hit(hit1[i])
    );
  end

  page_t sel0, sel1;

  // Scan high to low so the lowest-numbered matching entry is the one left standing.
  always_comb begin
    s0_found = 1'b0;
    s0_index = '0;
    sel0     = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit0[i]) begin
        s0_found = 1'b1;
        s0_index = i[IDX_W-1:0];
        sel0     = s0_odd_page ? page1_q[i] : page0_q[i];
      end
    end
  end

  always_comb begin
    s1_found = 1'b0;
    s1_index = '0;
    sel1     = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        s1_found = 1'b1;
        s1_index = i[IDX_W-1:0];
        sel1     = s1_odd_page ? page1_q[i] : page0_q[i];
      end
    end
  end

  assign s0_pfn = sel0.pfn;
  assign s0_c   = sel0.c;
  assign s0_d   = sel0.d;
  assign s0_v   = sel0.v;
  assign s1_pfn = sel1.pfn;
  assign s1_c   = sel1.c;
  assign s1_d   = sel1.d;
  assign s1_v   = sel1.v;

  assign r_vpn2 = vpn2_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_pfn0 = page0_q[r_index].pfn;
  assign r_c0   = page0_q[r_index].c;
  assign r_d0   = page0_q[r_index].d;
  assign r_v0   = page0_q[r_index].v;
  assign r_pfn1 = page1_q[r_index].pfn;
  assign r_c1   = page1_q[r_index].c;
  assign r_d1   = page1_q[r_index].d;
  assign r_v1   = page1_q[r_index].v;
endmodule

// File: doc/tlb.md
# tlb

Fully associative, 16-entry MIPS-style joint TLB holding the translation state that CP0 moves in and out via TLBWI/TLBR/TLBP. It provides two independent combinational lookup ports (port 0: instruction fetch; port 1: data access and TLBP probe), one synchronous write port driven from CP0 EntryHi/EntryLo0/EntryLo1/Index on TLBWI, and one combinational read port returning a full entry to CP0 on TLBR. Each entry maps an even/odd pair of 4 KB pages.

## Interface
- TLBNUM, 16, number of entries; index width is log2(TLBNUM) = 4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s0_vpn2  in  19  port-0 lookup VA[31:13]
- s0_odd_page  in  1  port-0 VA[12]; selects the odd page
- s0_asid  in  8  port-0 current ASID
- s0_found  out  1  port-0 hit
- s0_index  out  4  port-0 matching entry
- s0_pfn  out  20  port-0 selected page PFN
- s0_c  out  3  port-0 selected page cache attribute
- s0_d  out  1  port-0 selected page dirty (writable)
- s0_v  out  1  port-0 selected page valid
- s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v: port 1, same directions, widths and meanings as port 0
- we  in  1  write enable (TLBWI commit)
- w_index  in  4  entry to write
- w_vpn2  in  19, w_asid  in  8, w_g  in  1: tag fields
- w_pfn0  in  20, w_c0  in  3, w_d0  in  1, w_v0  in  1: even page
- w_pfn1  in  20, w_c1  in  3, w_d1  in  1, w_v1  in  1: odd page
- r_index  in  4  entry to read
- r_vpn2  out  19, r_asid  out  8, r_g  out  1, r_pfn0  out  20, r_c0  out  3, r_d0  out  1, r_v0  out  1, r_pfn1  out  20, r_c1  out  3, r_d1  out  1, r_v1  out  1: fields of entry r_index

## Operation
- Storage: per entry vpn2, asid, g, {pfn,c,d,v} for even and odd page; the only sequential state in the block.
- Reset: every field of every entry cleared to 0. Consequently all outputs read 0 after reset; lookup on vpn2=0 with asid=0 reports found=1, index 0, v=0 (a hit on an invalid page, not a miss).
- Match: entry i matches iff vpn2[i]==s_vpn2 and (g[i] or asid[i]==s_asid). The V bit does not participate in matching; V is reported in s_v so the caller distinguishes refill (found=0) from invalid (found=1, v=0).
- Multiple matches (software error): the lowest-numbered matching entry wins for index and page fields; no error is flagged.
- Miss: found=0, index=0, pfn/c/d/v=0.
- Page select: odd_page=0 returns the even-page fields, odd_page=1 returns the odd-page fields.
- Write: when we=1, all fields of entry w_index are replaced at the clock edge; G is a single per-entry bit taken from w_g.
- Read: r_* always reflect entry r_index; no enable.
- Ports 0, 1 and read are fully independent and usable in the same cycle.

## Timing
- Lookup and read: purely combinational, zero latency; CP0 samples s1_found/s1_index in the TLBP cycle.
- Write: takes effect at the posedge with we=1; visible on lookup/read ports from the next cycle. No same-cycle bypass: a lookup or read of the entry being written returns the old contents in that cycle.
- rst and we in the same cycle: reset wins; the entry stays 0.
- Back-to-back writes to the same index: last write wins; writes to different indices in consecutive cycles are independent.
- rst asserted mid-operation: all entries zero at the next edge regardless of any write in flight.

## Structure
- Shared package: TLBNUM, index width, field widths (VPN2=19, ASID=8, PFN=20, C=3) and the even/odd page field struct.
- One sub-module: tlb_match, per-entry match logic (vpn2/asid/g compare to 1-bit hit); instantiated TLBNUM times per lookup port. Priority encode and page mux live in the top level.

## Test plan
- Reset, then read r_index=5 and look up s0 vpn2=0x12345 asid=0x0A -> all r_* 0; s0_found=0, s0_index=0.
- Write idx 3: vpn2=0x12345 asid=0x0A g=0, pfn0=0x00100 c0=3 d0=1 v0=1, pfn1=0x00200 c1=2 d1=0 v1=1 -> next cycle s0 odd=0 asid=0x0A: found=1 index=3 pfn=0x00100 c=3 d=1 v=1; odd=1: pfn=0x00200 c=2 d=0 v=1; asid=0x0B: found=0.
- Write idx 7 vpn2=0x00400 asid=0x55 g=1 -> s1 vpn2=0x00400 asid=0xFF: found=1 index=7; simultaneous s0 miss on another vpn2 unaffected.
- Same vpn2/asid written to idx 9 then idx 2 with different pfn0 -> lookup returns index=2 and idx-2 pfn0.
- we to idx 4 with vpn2=0x7FFFF while s0 looks up 0x7FFFF in the same cycle -> found=0 that cycle, found=1 index=4 next cycle; repeat with rst=1 in the write cycle -> entry remains 0, found=0.
- Read idx 3 after scenario 2 -> r_* equal written fields, r_g=0; overwrite idx 3 with v0=0 -> r_v0=0 next cycle, lookup still found=1 with v=0.
